// File: rtl/lcd_clock_cal_v2.sv
// Settable calendar clock (leap-aware, optional 12-hour view) with a valid/ready time-set port,
// continuously refreshing an 8-bit HD44780 LCD: line 1 YYYY/MM/DD, line 2 hh:mm:ss [AM|PM].
module lcd_clock_cal_v2 #(
    parameter int unsigned CNT1MS           = 100000,
    parameter int unsigned STEP_MS          = 4,
    parameter int unsigned MS_PER_SEC       = 1000,
    parameter int unsigned INIT_DELAY_STEPS = 5,
    parameter int unsigned YEAR_RST         = 2024
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        set_valid_i,
    output logic        set_ready_o,
    input  logic [13:0] set_year_i,
    input  logic [3:0]  set_month_i,
    input  logic [4:0]  set_day_i,
    input  logic [4:0]  set_hour_i,
    input  logic [5:0]  set_min_i,
    input  logic [5:0]  set_sec_i,
    output logic        set_err_o,
    input  logic        mode_12h_i,
    output logic        sec_pulse_o,
    output logic        lcd_e_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    localparam int unsigned CW = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
    localparam int unsigned SW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;

    localparam logic [1:0] StInit = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StChar = 2'd2;

    function automatic logic is_leap(input logic [13:0] y);
        return (((y % 14'd4) == 14'd0) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        logic [4:0] d;
        case (m)
            4'd2:                    d = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] dig(input logic [13:0] v);
        logic [13:0] r;
        r = v % 14'd10;
        return 8'h30 + r[7:0];
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    ms_step_q, ms_step_d;
    logic [SW-1:0] ms_sec_q, ms_sec_d;
    logic [13:0]   year_q, year_d;
    logic [3:0]    month_q, month_d;
    logic [4:0]    day_q, day_d, hour_q, hour_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic          set_ready_q, set_err_q, sec_pulse_q;
    logic [1:0]    state_q, state_d;
    logic [15:0]   init_idx_q, init_idx_d;
    logic          line_q, line_d, rs_q, rs_d, active_q, active_d;
    logic [3:0]    col_q, col_d;
    logic [7:0]    data_q, data_d;
    logic [40:0]   sh_q, sh_d;

    logic        tick_ms, step_start, sec_tick, xfer, set_ok, accept;
    logic [7:0]  init_byte, char_byte;
    logic [15:0] cmd_idx;
    logic        sh_12h;
    logic [13:0] sh_year;
    logic [3:0]  sh_month;
    logic [4:0]  sh_day, sh_hour, hour_disp;
    logic [5:0]  sh_min, sh_sec;

    assign tick_ms    = (cnt_q == CW'(CNT1MS - 1));
    assign step_start = tick_ms && (ms_step_q == 4'(STEP_MS - 1));
    assign sec_tick   = tick_ms && (ms_sec_q == SW'(MS_PER_SEC - 1));
    assign xfer       = set_valid_i && set_ready_q;
    assign set_ok     = (set_year_i <= 14'd9999) && (set_month_i >= 4'd1) &&
                        (set_month_i <= 4'd12) && (set_day_i >= 5'd1) &&
                        (set_day_i <= days_in_month(set_month_i, is_leap(set_year_i))) &&
                        (set_hour_i <= 5'd23) && (set_min_i <= 6'd59) && (set_sec_i <= 6'd59);
    assign accept     = xfer && set_ok;

    // Prescalers and calendar; an accepted set beats a coincident second tick.
    always_comb begin
        cnt_d     = tick_ms ? '0 : cnt_q + 1'b1;
        ms_step_d = ms_step_q;
        ms_sec_d  = ms_sec_q;
        if (tick_ms) begin
            ms_step_d = step_start ? 4'd0 : ms_step_q + 4'd1;
            ms_sec_d  = sec_tick ? '0 : ms_sec_q + 1'b1;
        end
        if (accept) ms_sec_d = '0;

        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (accept) begin
            year_d  = set_year_i;
            month_d = set_month_i;
            day_d   = set_day_i;
            hour_d  = set_hour_i;
            min_d   = set_min_i;
            sec_d   = set_sec_i;
        end else if (sec_tick) begin
            if (sec_q != 6'd59) sec_d = sec_q + 6'd1;
            else begin
                sec_d = '0;
                if (min_q != 6'd59) min_d = min_q + 6'd1;
                else begin
                    min_d = '0;
                    if (hour_q != 5'd23) hour_d = hour_q + 5'd1;
                    else begin
                        hour_d = '0;
                        if (day_q != days_in_month(month_q, is_leap(year_q))) begin
                            day_d = day_q + 5'd1;
                        end else begin
                            day_d = 5'd1;
                            if (month_q != 4'd12) month_d = month_q + 4'd1;
                            else begin
                                month_d = 4'd1;
                                year_d  = (year_q == 14'd9999) ? '0 : year_q + 14'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign cmd_idx = init_idx_q - 16'(INIT_DELAY_STEPS);

    always_comb begin
        init_byte = 8'h00;
        if (init_idx_q >= 16'(INIT_DELAY_STEPS)) begin
            case (cmd_idx)
                16'd0:   init_byte = 8'h38;
                16'd1:   init_byte = 8'h08;
                16'd2:   init_byte = 8'h01;
                16'd3:   init_byte = 8'h06;
                16'd4:   init_byte = 8'h0C;
                default: init_byte = 8'h02;
            endcase
        end
    end

    assign {sh_12h, sh_year, sh_month, sh_day, sh_hour, sh_min, sh_sec} = sh_q;

    always_comb begin
        hour_disp = sh_hour;
        if (sh_12h) begin
            if (sh_hour == 5'd0)      hour_disp = 5'd12;
            else if (sh_hour > 5'd12) hour_disp = sh_hour - 5'd12;
        end
    end

    always_comb begin
        char_byte = 8'h20;
        if (!line_q) begin
            case (col_q)
                4'd0:       char_byte = dig(sh_year / 14'd1000);
                4'd1:       char_byte = dig(sh_year / 14'd100);
                4'd2:       char_byte = dig(sh_year / 14'd10);
                4'd3:       char_byte = dig(sh_year);
                4'd4, 4'd7: char_byte = 8'h2F;
                4'd5:       char_byte = dig(14'(sh_month) / 14'd10);
                4'd6:       char_byte = dig(14'(sh_month));
                4'd8:       char_byte = dig(14'(sh_day) / 14'd10);
                4'd9:       char_byte = dig(14'(sh_day));
                default:    char_byte = 8'h20;
            endcase
        end else begin
            case (col_q)
                4'd0:       char_byte = dig(14'(hour_disp) / 14'd10);
                4'd1:       char_byte = dig(14'(hour_disp));
                4'd2, 4'd5: char_byte = 8'h3A;
                4'd3:       char_byte = dig(14'(sh_min) / 14'd10);
                4'd4:       char_byte = dig(14'(sh_min));
                4'd6:       char_byte = dig(14'(sh_sec) / 14'd10);
                4'd7:       char_byte = dig(14'(sh_sec));
                4'd9:       char_byte = sh_12h ? ((sh_hour >= 5'd12) ? 8'h50 : 8'h41) : 8'h20;
                4'd10:      char_byte = sh_12h ? 8'h4D : 8'h20;
                default:    char_byte = 8'h20;
            endcase
        end
    end

    // LCD step sequencer: bus values change only on a step boundary.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        line_d     = line_q;
        col_d      = col_q;
        rs_d       = rs_q;
        data_d     = data_q;
        active_d   = active_q;
        sh_d       = sh_q;
        if (step_start) begin
            active_d = 1'b1;
            case (state_q)
                StInit: begin
                    rs_d   = 1'b0;
                    data_d = init_byte;
                    if (init_idx_q == 16'(INIT_DELAY_STEPS + 5)) begin
                        state_d = StAddr;
                        line_d  = 1'b0;
                    end else begin
                        init_idx_d = init_idx_q + 16'd1;
                    end
                end
                StAddr: begin
                    rs_d    = 1'b0;
                    data_d  = line_q ? 8'hC0 : 8'h80;
                    sh_d    = {mode_12h_i, year_q, month_q, day_q, hour_q, min_q, sec_q};
                    col_d   = 4'd0;
                    state_d = StChar;
                end
                StChar: begin
                    rs_d   = 1'b1;
                    data_d = char_byte;
                    if (col_q == 4'd15) begin
                        line_d  = ~line_q;
                        state_d = StAddr;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q       <= '0;
            ms_step_q   <= '0;
            ms_sec_q    <= '0;
            year_q      <= 14'(YEAR_RST);
            month_q     <= 4'd1;
            day_q       <= 5'd1;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            set_ready_q <= 1'b1;
            set_err_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
            state_q     <= StInit;
            init_idx_q  <= '0;
            line_q      <= 1'b0;
            col_q       <= '0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            active_q    <= 1'b0;
            sh_q        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ms_step_q   <= ms_step_d;
            ms_sec_q    <= ms_sec_d;
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            set_ready_q <= !xfer;
            set_err_q   <= xfer && !set_ok;
            sec_pulse_q <= sec_tick && !accept;
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            line_q      <= line_d;
            col_q       <= col_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            active_q    <= active_d;
            sh_q        <= sh_d;
        end
    end

    // E is held off until the first step has put real data on the bus.
    assign lcd_e_o     = active_q && (ms_step_q == 4'd1);
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;
    assign set_ready_o = set_ready_q;
    assign set_err_o   = set_err_q;
    assign sec_pulse_o = sec_pulse_q;

endmodule

// File: tb/tb_lcd_clock_cal_v2.sv
// Scoreboard bench for lcd_clock_cal_v2: a timeline/calendar model predicts every LCD write and
// handshake output; a negedge monitor compares the DUT against it.
module tb_lcd_clock_cal_v2;

    localparam int CNT1MS     = 4;
    localparam int STEP_MS    = 4;
    localparam int MS_PER_SEC = 100;
    localparam int INIT_STEPS = 5;
    localparam int YEAR_RST   = 2024;
    localparam int FRAME      = 34;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        set_valid = 1'b0;
    logic        set_ready;
    logic [13:0] set_year = '0;
    logic [3:0]  set_month = '0;
    logic [4:0]  set_day = '0;
    logic [4:0]  set_hour = '0;
    logic [5:0]  set_min = '0;
    logic [5:0]  set_sec = '0;
    logic        set_err;
    logic        mode12 = 1'b0;
    logic        sec_pulse, lcd_e, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_clock_cal_v2 #(
        .CNT1MS          (CNT1MS),
        .STEP_MS         (STEP_MS),
        .MS_PER_SEC      (MS_PER_SEC),
        .INIT_DELAY_STEPS(INIT_STEPS),
        .YEAR_RST        (YEAR_RST)
    ) dut (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .set_valid_i(set_valid),
        .set_ready_o(set_ready),
        .set_year_i (set_year),
        .set_month_i(set_month),
        .set_day_i  (set_day),
        .set_hour_i (set_hour),
        .set_min_i  (set_min),
        .set_sec_i  (set_sec),
        .set_err_o  (set_err),
        .mode_12h_i (mode12),
        .sec_pulse_o(sec_pulse),
        .lcd_e_o    (lcd_e),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_data_o (lcd_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_y, m_mo, m_d, m_h, m_mi, m_s;
    int n_edge, base_ms;
    int last_p = -1;
    bit model_ok = 1'b0;
    bit ready_m, exp_ready, exp_err, exp_spulse, exp_e;
    bit e_prev = 1'b0;
    logic [8:0] exp_bus;
    logic [8:0] sb_q[$];
    string txt;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic bit is_leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim(int mo, int y);
        int len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return (mo == 2 && is_leap(y)) ? 29 : len[mo-1];
    endfunction

    function automatic bit fields_ok(int y, int mo, int d, int h, int mi, int s);
        if (y > 9999 || mo < 1 || mo > 12 || h > 23 || mi > 59 || s > 59) return 1'b0;
        return (d >= 1) && (d <= dim(mo, y));
    endfunction

    function automatic bit sec_at(int n);
        int ms = n / CNT1MS;
        return (n % CNT1MS == 0) && (ms > base_ms) && ((ms - base_ms) % MS_PER_SEC == 0);
    endfunction

    function automatic void advance_second();
        m_s++;
        if (m_s == 60) begin m_s = 0; m_mi++; end
        if (m_mi == 60) begin m_mi = 0; m_h++; end
        if (m_h == 24) begin m_h = 0; m_d++; end
        if (m_d > dim(m_mo, m_y)) begin m_d = 1; m_mo++; end
        if (m_mo == 13) begin m_mo = 1; m_y = (m_y + 1) % 10000; end
    endfunction

    function automatic string line1_text();
        int hh;
        if (!mode12) return $sformatf("%02d:%02d:%02d        ", m_h, m_mi, m_s);
        hh = (m_h % 12 == 0) ? 12 : m_h % 12;
        return $sformatf("%02d:%02d:%02d %s     ", hh, m_mi, m_s, (m_h < 12) ? "AM" : "PM");
    endfunction

    function automatic void emit_step(int k);
        logic [8:0] b;
        byte c;
        int p;
        if (k <= INIT_STEPS) b = 9'h000;
        else if (k <= INIT_STEPS + 6) begin
            case (k - INIT_STEPS)
                1: b = 9'h038;
                2: b = 9'h008;
                3: b = 9'h001;
                4: b = 9'h006;
                5: b = 9'h00C;
                default: b = 9'h002;
            endcase
        end else begin
            p = (k - INIT_STEPS - 7) % FRAME;
            last_p = p;
            if (p == 0) begin
                txt = $sformatf("%04d/%02d/%02d      ", m_y, m_mo, m_d);
                b = 9'h080;
            end else if (p == 17) begin
                txt = line1_text();
                b = 9'h0C0;
            end else begin
                c = txt[(p < 17) ? p - 1 : p - 18];
                b = {1'b1, c};
            end
        end
        sb_q.push_back(b);
        exp_bus = b;
    endfunction

    // Model: evaluates each clock edge from the bench's own inputs and timeline arithmetic.
    initial begin : model
        int ms;
        bit xfer, ok, sec;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_y = YEAR_RST; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
                n_edge = 1; base_ms = 0; last_p = -1; ready_m = 1'b1;
                exp_ready = 1'b1; exp_err = 1'b0; exp_spulse = 1'b0; exp_e = 1'b0;
                exp_bus = 9'h000;
                sb_q.delete();
                model_ok = 1'b1;
            end else if (model_ok) begin
                ms   = n_edge / CNT1MS;
                sec  = sec_at(n_edge);
                xfer = set_valid && ready_m;
                ok   = fields_ok(int'(set_year), int'(set_month), int'(set_day), int'(set_hour),
                                 int'(set_min), int'(set_sec));
                if ((n_edge % CNT1MS == 0) && (ms % STEP_MS == 0)) emit_step(ms / STEP_MS);
                exp_err    = xfer && !ok;
                exp_spulse = sec && !(xfer && ok);
                if (xfer && ok) begin
                    m_y = int'(set_year); m_mo = int'(set_month); m_d = int'(set_day);
                    m_h = int'(set_hour); m_mi = int'(set_min); m_s = int'(set_sec);
                    base_ms = ms;
                end else if (sec) begin
                    advance_second();
                end
                ready_m   = !xfer;
                exp_ready = ready_m;
                exp_e     = (ms % STEP_MS == 1) && (ms > STEP_MS);
                n_edge++;
            end
        end
    end

    // Monitor: per-cycle outputs, plus scoreboard pop on every E strobe.
    initial begin : monitor
        logic [8:0] want;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                check("set_ready", set_ready, exp_ready);
                check("set_err", set_err, exp_err);
                check("sec_pulse", sec_pulse, exp_spulse);
                check("lcd_e", lcd_e, exp_e);
                check("lcd_rw", lcd_rw, 0);
                check("lcd_bus", {lcd_rs, lcd_data}, exp_bus);
                if (lcd_e && !e_prev) begin
                    check("sb_depth", sb_q.size(), 1);
                    if (sb_q.size() > 0) begin
                        want = sb_q.pop_front();
                        check("e_strobe_write", {lcd_rs, lcd_data}, want);
                    end
                end
                e_prev = lcd_e;
            end
        end
    end

    task automatic run(int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic do_set(int y, int mo, int d, int h, int mi, int s, bit avoid_sec);
        int guard = 0;
        while ((!ready_m || (avoid_sec && sec_at(n_edge))) && guard < 20) begin
            run(1);
            guard++;
        end
        check("set_wait_bound", guard < 20, 1);
        set_year = 14'(y); set_month = 4'(mo); set_day = 5'(d);
        set_hour = 5'(h);  set_min = 6'(mi);   set_sec = 6'(s);
        set_valid = 1'b1;
        run(1);
        set_valid = 1'b0;
    endtask

    task automatic bad_set();
        int y = $urandom_range(0, 9999), mo = $urandom_range(1, 12), d = 1;
        int h = $urandom_range(0, 23), mi = $urandom_range(0, 59), s = $urandom_range(0, 59);
        case ($urandom_range(0, 5))
            0: y = $urandom_range(10000, 16383);
            1: mo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(13, 15);
            2: d = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(dim(mo, y) + 1, 31);
            3: h = $urandom_range(24, 31);
            4: mi = $urandom_range(60, 63);
            default: s = $urandom_range(60, 63);
        endcase
        do_set(y, mo, d, h, mi, s, 1'b1);
        run($urandom_range(2, 20));
    endtask

    initial begin : stimulus
        int guard;
        int y, mo;
        run(3);
        resetn = 1'b1;
        run(800);

        do_set(2024, 2, 28, 23, 59, 59, 1'b0);
        run(1300);
        do_set(2100, 2, 28, 23, 59, 59, 1'b0);
        run(1300);
        do_set(9999, 12, 31, 23, 59, 59, 1'b0);
        run(1300);

        do_set(2023, 2, 29, 0, 0, 0, 1'b1);
        run(40);
        repeat (6) bad_set();

        mode12 = 1'b1;
        do_set(2024, 5, 5, 0, 0, 0, 1'b0);
        run(1200);
        do_set(2024, 5, 5, 12, 0, 0, 1'b0);
        run(1200);
        do_set(2024, 5, 5, 13, 0, 0, 1'b0);
        run(1200);
        mode12 = 1'b0;

        // Set lands on the same edge as a second tick.
        guard = 0;
        while (!(sec_at(n_edge) && ready_m) && guard < 2000) begin run(1); guard++; end
        check("sec_align_bound", guard < 2000, 1);
        do_set(2024, 6, 1, 10, 0, 0, 1'b0);
        run(1300);

        // Held valid: back-to-back transfers separated by one not-ready cycle.
        set_year = 14'd2030; set_month = 4'd7; set_day = 5'd4;
        set_hour = 5'd8; set_min = 6'd30; set_sec = 6'd0;
        set_valid = 1'b1;
        run(1);
        set_day = 5'd31;
        run(3);
        set_valid = 1'b0;
        run(600);

        repeat (8) begin
            y = $urandom_range(0, 9999);
            mo = $urandom_range(1, 12);
            mode12 = 1'($urandom_range(0, 1));
            do_set(y, mo, $urandom_range(1, dim(mo, y)), $urandom_range(0, 23),
                   $urandom_range(0, 59), $urandom_range(0, 59), 1'b0);
            run($urandom_range(200, 900));
        end

        // Reset just after the line-0 column-7 write, before its E strobe.
        guard = 0;
        while (last_p == 8 && guard < 2000) begin run(1); guard++; end
        while (last_p != 8 && guard < 2000) begin run(1); guard++; end
        check("col7_wait_bound", guard < 2000, 1);
        run(1);
        resetn = 1'b0;
        run(2);
        resetn = 1'b1;
        run(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_clock_cal_v2.md
Name: lcd_clock_cal_v2

Overview:
Parametrised successor of the 16x2 HD44780 date/time clock. It combines three parts:
- a settable calendar clock with correct leap-year handling and an optional 12-hour display mode;
- a valid/ready time-set port;
- a generalised LCD writer with configurable timing.

It sits between the board clock/reset and the 8-bit HD44780 LCD pins, and continuously refreshes line 1 (date) and line 2 (time).

Parameters:
CNT1MS, 100000, clk cycles per 1 ms tick (shrink for simulation).
STEP_MS, 4, ms per LCD bus step; legal range 3..15.
MS_PER_SEC, 1000, ms ticks per calendar second (shrink for accelerated runs).
INIT_DELAY_STEPS, 5, idle steps (data 0x00, rs 0) issued before the command list.
YEAR_RST, 2024, year loaded at reset; the reset date/time is YEAR_RST/01/01 00:00:00.

Ports:
clk in 1 system clock
resetn in 1 synchronous active-low reset
set_valid in 1 time-set request
set_ready out 1 time-set port can accept
set_year in 14 0..9999
set_month in 4 1..12
set_day in 5 1..days_in_month
set_hour in 5 0..23
set_min in 6 0..59
set_sec in 6 0..59
set_err out 1 one-cycle pulse: the set request was rejected
mode_12h in 1 1 = 12-hour display with AM/PM
sec_pulse out 1 one-cycle pulse on each calendar second advance
lcd_e out 1 LCD enable
lcd_rs out 1 LCD register select
lcd_rw out 1 constant 0
lcd_data out 8 LCD data bus

Behaviour:
- Reset: sync, active-low, sampled on posedge clk only.
  - Outputs at reset: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, set_ready=1, set_err=0, sec_pulse=0.
  - Internal state at reset: all counters 0, FSM in INIT, calendar at reset value.
  - Reset mid-operation (any state) aborts the current LCD step immediately; no partial E pulse follows.
- Ticks:
  - tick_ms: one-cycle pulse every CNT1MS clks.
  - step_start: every STEP_MS tick_ms; ms_in_step counts 0..STEP_MS-1.
  - sec_tick: every MS_PER_SEC tick_ms.
- Calendar:
  - On sec_tick: seconds cascade 59->0 into min, min into hour, 23->0 into day.
  - Day limits: 31 for Jan/Mar/May/Jul/Aug/Oct/Dec, 30 for Apr/Jun/Sep/Nov. February is 29 if leap, else 28.
  - Leap year: (y%4==0 && y%100!=0) || y%400==0.
  - month 12 -> 1 with year+1; year 9999 wraps to 0000.
  - sec_pulse asserts in the cycle after each applied sec_tick.
- Set handshake:
  - Transfer when set_valid && set_ready.
  - Valid fields: all loaded on the next edge.
  - Any field out of range: nothing changes and set_err pulses on the next cycle.
  - set_ready drops for exactly 1 cycle after any transfer (accepted or rejected).
  - Set and sec_tick in the same cycle: the set wins, that tick is discarded, and sec_pulse is not asserted.
  - The ms/second prescaler is cleared on an accepted set, so the first advance comes a full MS_PER_SEC ms later.
- LCD FSM (state changes only on step_start):
  - INIT:
    - INIT_DELAY_STEPS steps of 0x00, then commands 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02, all with rs=0.
    - Then go to ADDR with line=0.
  - ADDR:
    - rs=0; data 0x80 for line 0, 0xC0 for line 1.
    - Snapshot all calendar fields into a display shadow (prevents tearing within a line).
    - Go to CHAR with col=0.
  - CHAR:
    - rs=1; data = char(line, col) taken from the shadow.
    - col 0..15; after col 15, toggle line and go to ADDR.
    - Steady refresh is 34 steps per frame.
- Characters:
  - Line 0: "YYYY/MM/DD" followed by 6 spaces.
  - Line 1, mode_12h=0: "hh:mm:ss" followed by 8 spaces.
  - Line 1, mode_12h=1: "hh:mm:ss AM" / "hh:mm:ss PM" followed by 5 spaces.
    - Hour 0 displays as 12 AM, hour 12 as 12 PM, hours 13..23 as 01..11 PM.
  - Digits are 0x30+n, '/' = 0x2F, ':' = 0x3A, space = 0x20, 'A' = 0x41, 'P' = 0x50, 'M' = 0x4D.
  - mode_12h is sampled with the snapshot at ADDR.
- Bus timing:
  - lcd_rs and lcd_data update on the cycle after step_start and hold for the whole step.
  - lcd_e is high exactly while ms_in_step==1: one ms wide, starting 1 ms after the data changes and ending at least 1 ms before the next change.

Test Plan:
- Reset, CNT1MS=4, STEP_MS=4 -> 5 E pulses with data 0x00, then 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02 (rs=0), then 0x80 and "2024/01/01" (rs=1).
- Set 2024/02/28 23:59:59, one sec_tick -> line 0 shows "2024/02/29"; set 2100/02/28 23:59:59, one sec_tick -> "2100/03/01"; set 9999/12/31 23:59:59, one sec_tick -> "0000/01/01 00:00:00".
- Set 2023/02/29 00:00:00 -> set_err high for 1 cycle, calendar unchanged, set_ready low for 1 cycle then high.
- mode_12h=1: hour 0 -> "12:..:.. AM"; hour 12 -> "12 PM"; hour 13 -> "01:..:.. PM".
- set_valid asserted in the same cycle as sec_tick with 10:00:00 -> display shows 10:00:00, no sec_pulse that cycle, next advance to 10:00:01 after MS_PER_SEC ms.
- resetn low during CHAR col 7 -> all outputs reset the next cycle; sequence restarts from INIT delay steps.
